// File: rtl/fsm_palin_win_det.sv
// Windowed palindrome detector over a stream of W-bit symbols.
// Sliding or framed evaluation, with a registered det pulse and a saturating hit counter.
module fsm_palin_win_det #(
    parameter int N     = 4,
    parameter int W     = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     ser_in,
    input  logic             in_valid,
    input  logic             mode,
    input  logic             clr,
    output logic             det,
    output logic             full,
    output logic [CNT_W-1:0] det_cnt
);

    localparam int FW = $clog2(N + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(N);
    localparam logic [FW-1:0] FILL_ONE = FW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic [FW-1:0] fill, fill_nxt;

    // Only the newest N-1 symbols are stored; the oldest one of the
    // N-symbol window is shifted out on the very accept that would need it.
    logic [N-2:0][W-1:0] hist, hist_nxt;
    logic [N-1:0][W-1:0] win_nxt;

    logic accept;
    logic eval;
    logic pal;
    logic det_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    assign accept  = in_valid && !clr;
    assign win_nxt = {hist, ser_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            fill    <= '0;
            hist    <= '0;
            det     <= 1'b0;
            det_cnt <= '0;
        end else if (clr) begin
            state   <= EMPTY;
            fill    <= '0;
            hist    <= '0;
            det     <= 1'b0;
            det_cnt <= '0;
        end else begin
            state   <= state_nxt;
            fill    <= fill_nxt;
            hist    <= hist_nxt;
            det     <= det_nxt;
            det_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fill_nxt  = fill;
        hist_nxt  = hist;
        eval      = 1'b0;
        if (accept) begin
            hist_nxt = win_nxt[N-2:0];
            unique case (state)
                EMPTY: begin
                    fill_nxt  = FILL_ONE;
                    state_nxt = FILL;
                end
                FILL: begin
                    if (fill == FILL_MAX - FILL_ONE) begin
                        eval = 1'b1;
                        if (mode) begin
                            fill_nxt  = '0;
                            state_nxt = EMPTY;
                        end else begin
                            fill_nxt  = FILL_MAX;
                            state_nxt = FULL;
                        end
                    end else begin
                        fill_nxt = fill + FILL_ONE;
                    end
                end
                FULL: begin
                    // Switching to framed restarts counting with this symbol as #1.
                    if (mode) begin
                        fill_nxt  = FILL_ONE;
                        state_nxt = FILL;
                    end else begin
                        eval = 1'b1;
                    end
                end
                default: begin
                    fill_nxt  = '0;
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    always_comb begin
        pal = 1'b1;
        for (int k = 0; k < N / 2; k++) begin
            if (win_nxt[k] != win_nxt[N-1-k]) begin
                pal = 1'b0;
            end
        end
    end

    always_comb begin
        full    = (state == FULL);
        det_nxt = eval && pal;
        cnt_nxt = det_cnt;
        if (det_nxt && det_cnt != CNT_MAX) begin
            cnt_nxt = det_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fsm_palin_win_det.sv
// Bench for fsm_palin_win_det: three parameterisations driven in lockstep,
// checked every cycle against a list-based model plus directed literal checks.
module tb_fsm_palin_win_det;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sym;
    logic       vld;
    logic       md;
    logic       clr;

    logic       det0, det1, det2;
    logic       full0, full1, full2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fsm_palin_win_det #(.N(4), .W(1), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .ser_in(sym[0:0]), .in_valid(vld),
        .mode(md), .clr(clr), .det(det0), .full(full0), .det_cnt(cnt0)
    );

    fsm_palin_win_det #(.N(4), .W(2), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .ser_in(sym), .in_valid(vld),
        .mode(md), .clr(clr), .det(det1), .full(full1), .det_cnt(cnt1)
    );

    fsm_palin_win_det #(.N(2), .W(1), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .ser_in(sym[0:0]), .in_valid(vld),
        .mode(md), .clr(clr), .det(det2), .full(full2), .det_cnt(cnt2)
    );

    // Model: per instance, the symbol history (newest first), how many
    // symbols of the current block have arrived, and whether sliding is live.
    int m_win [3][32];
    int m_fill[3];
    bit m_run [3];
    bit m_det [3];
    int m_cnt [3];
    bit m_ev;

    function automatic int nn(input int i);
        return (i == 2) ? 2 : 4;
    endfunction

    function automatic int cmax(input int i);
        return (i == 2) ? 3 : 255;
    endfunction

    function automatic bit pal(input int i);
        for (int k = 0; k < nn(i) / 2; k++)
            if (m_win[i][k] != m_win[i][nn(i)-1-k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (rst || clr) begin
                m_fill[i] = 0;
                m_run[i]  = 1'b0;
                m_det[i]  = 1'b0;
                m_cnt[i]  = 0;
            end else begin
                m_det[i] = 1'b0;
                if (vld) begin
                    m_ev = 1'b0;
                    for (int k = 31; k > 0; k--) m_win[i][k] = m_win[i][k-1];
                    m_win[i][0] = (i == 1) ? int'(sym) : int'(sym[0]);
                    if (m_run[i] && !md) begin
                        m_ev = 1'b1;
                    end else if (m_run[i]) begin
                        m_run[i]  = 1'b0;
                        m_fill[i] = 1;
                    end else begin
                        m_fill[i]++;
                        if (m_fill[i] == nn(i)) begin
                            m_ev = 1'b1;
                            if (md) m_fill[i] = 0;
                            else m_run[i] = 1'b1;
                        end
                    end
                    if (m_ev && pal(i)) begin
                        m_det[i] = 1'b1;
                        if (m_cnt[i] < cmax(i)) m_cnt[i]++;
                    end
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cyc_det0",  int'(det0),  int'(m_det[0]));
        chk("cyc_full0", int'(full0), int'(m_run[0]));
        chk("cyc_cnt0",  int'(cnt0),  m_cnt[0]);
        chk("cyc_det1",  int'(det1),  int'(m_det[1]));
        chk("cyc_full1", int'(full1), int'(m_run[1]));
        chk("cyc_cnt1",  int'(cnt1),  m_cnt[1]);
        chk("cyc_det2",  int'(det2),  int'(m_det[2]));
        chk("cyc_full2", int'(full2), int'(m_run[2]));
        chk("cyc_cnt2",  int'(cnt2),  m_cnt[2]);
    end

    task automatic cyc(input logic [1:0] s, input logic v,
                       input logic m, input logic c);
        sym = s;
        vld = v;
        md  = m;
        clr = c;
        @(posedge clk);
        #2;
    endtask

    int s1[7]  = '{1, 0, 0, 1, 0, 0, 1};
    int e1[7]  = '{0, 0, 0, 1, 0, 0, 1};
    int s2[12] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 0};
    int e2[12] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    int s4a[4] = '{2, 1, 1, 2};
    int s4b[4] = '{2, 1, 2, 1};
    int pulses;

    initial begin
        sym = 2'd0;
        vld = 1'b0;
        md  = 1'b0;
        clr = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #10;
        chk("rst_det",  int'(det0),  0);
        chk("rst_full", int'(full0), 0);
        chk("rst_cnt",  int'(cnt0),  0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Sliding N=4
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 7; i++) begin
            cyc(2'(s1[i]), 1, 0, 0);
            chk("slide_det", int'(det0), e1[i]);
            if (i == 3) chk("slide_full", int'(full0), 1);
        end
        chk("slide_cnt", int'(cnt0), 2);

        // Framed N=4
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 12; i++) begin
            cyc(2'(s2[i]), 1, 1, 0);
            chk("frame_det", int'(det0), e2[i]);
            chk("frame_full", int'(full0), 0);
        end
        chk("frame_cnt", int'(cnt0), 2);

        // Valid gaps
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(2'(s1[i]), 1, 0, 0);
            chk("gap_det", int'(det0), (i == 3) ? 1 : 0);
            for (int g = 0; g < 3; g++) begin
                cyc(0, 0, 0, 0);
                chk("gap_idle_det", int'(det0), 0);
            end
        end
        chk("gap_cnt", int'(cnt0), 1);

        // Whole-symbol compare, W=2
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(2'(s4a[i]), 1, 0, 0);
        chk("w2_pal_det", int'(det1), 1);
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(2'(s4b[i]), 1, 0, 0);
        chk("w2_nopal_det", int'(det1), 0);
        chk("w2_nopal_cnt", int'(cnt1), 0);

        // clr mid-fill restarts the block
        cyc(0, 0, 0, 1);
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 1);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("clr_det", int'(det0), 0);
        chk("clr_full", int'(full0), 0);
        chk("clr_cnt", int'(cnt0), 0);

        // Async reset while FULL and det is high
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(2'(s1[i]), 1, 0, 0);
        vld = 1'b0;
        chk("pre_rst_det", int'(det0), 1);
        chk("pre_rst_full", int'(full0), 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_det", int'(det0), 0);
        chk("arst_full", int'(full0), 0);
        chk("arst_cnt", int'(cnt0), 0);
        #2 rst = 1'b0;
        @(posedge clk);
        #2;

        // Saturation on the N=2, CNT_W=2 instance
        cyc(0, 0, 0, 1);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 0, 0);
            if (det2) pulses++;
        end
        chk("sat_pulses", pulses, 5);
        chk("sat_cnt", int'(cnt2), 3);
        cyc(0, 1, 0, 0);
        chk("sat_hold", int'(cnt2), 3);
        cyc(0, 0, 0, 0);
        chk("sat_idle_det", int'(det2), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_palin_win_det.md
Name: fsm_palin_win_det

Overview:
- Parametrised successor to the single-bit serial palindrome detector.
- Accepts a stream of W-bit symbols with a valid qualifier and keeps the last N symbols in a window.
- Flags when that window reads the same forwards and backwards, compared symbol-by-symbol.
- Supports sliding (overlapping) or framed (non-overlapping block) evaluation, a synchronous clear and a saturating hit counter; sits behind a serial front end in the datapath.

Parameters:
- N, 4, window length in symbols; legal range 2..32.
- W, 1, symbol width in bits; legal range 1..8.
- CNT_W, 8, width of the saturating hit counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- ser_in  input  W  incoming symbol.
- in_valid  input  1  ser_in accepted on a rising clk edge when high.
- mode  input  1  0 = sliding window, 1 = framed blocks of N; sampled only on accepted symbols.
- clr  input  1  synchronous clear of window, fill count, det and det_cnt.
- det  output  1  one-cycle registered pulse, high when the just-completed window is a palindrome.
- full  output  1  high while the window holds N valid symbols (sliding mode); always 0 in framed mode.
- det_cnt  output  CNT_W  number of det pulses since reset/clr, saturating at all-ones.

Behaviour:
- Reset (async, rst=1): window=0, fill=0, state=EMPTY, det=0, full=0, det_cnt=0. Outputs take reset values immediately, not at the next edge.
- Priority at a clock edge: rst > clr > accepted symbol. With clr=1, in_valid is ignored that cycle; all state returns to reset values on that edge.
- Window shift: on accept, win[0] <= ser_in and win[k] <= win[k-1]; win[0] is the newest symbol.
- Palindrome test: computed on the post-shift window as win[k]==win[N-1-k] for k < N/2, comparing whole W-bit symbols. The middle symbol of odd N is ignored.
- det is registered, with latency 1.
  - det is high in the cycle after the edge that accepts the symbol completing an evaluable window, and only if the test passes.
  - det is 0 in every other cycle, including in_valid=0 cycles.
- State machine, with fill counter width clog2(N+1):
  - EMPTY: fill=0. On accept: fill=1, go to FILL.
  - FILL: on accept, fill++.
    - Sliding mode: when fill reaches N, evaluate the window and go to FULL.
    - Framed mode: when fill reaches N, evaluate the window, set fill=0 and go to EMPTY. The window is not cleared, but the next block must supply N fresh symbols before it is evaluated.
  - FULL (sliding only): every accept evaluates the window; fill holds at N.
    - If mode=1 is sampled on an accept while in FULL, that accept is treated as symbol 1 of a new frame: fill=1, go to FILL, no evaluation.
  - in_valid=0: state, fill and window hold.
- full = (state==FULL).
- det_cnt increments on each edge that sets det=1 and holds at 2^CNT_W-1 once reached.
- A symbol arriving while a det pulse is being output is handled normally, so back-to-back det pulses are legal in sliding mode.
- Mid-operation rst or clr discards a partial window; no det is produced for it.

Test Plan:
- Sliding detection, N=4, W=1, mode=0, in_valid=1: stream 1,0,0,1,0,0,1 → det pulses one cycle after symbols 4 and 7 only; full rises after symbol 4; det_cnt=2.
- Framed detection, N=4, W=1, mode=1: stream 1,0,0,1, 0,0,1,0, 0,1,1,0 → det after symbols 4 and 12 only; no det after symbol 8; full stays 0; det_cnt=2.
- Valid gaps: stream 1,0,0,1 with in_valid low for 3 cycles between each symbol → single det one cycle after the 4th accept; fill holds during the gaps; det is low during gap cycles.
- Symbol-level compare, N=4, W=2: symbols 2,1,1,2 → det=1. Symbols 2,1,2,1 → no det.
- Clear and reset mid-fill:
  - Accept 1,0, then clr=1 with in_valid=1, then 0,1 → no det (fill restarts at 0).
  - Assert rst asynchronously between edges in FULL → det, full and det_cnt go to 0 before the next edge.
- Saturation, CNT_W=2, sliding, N=2: stream 0,0,0,0,0,0 → 5 det pulses; det_cnt reads 3 and stays at 3.
